// File: rtl/axi_rd_id_seq_pkg.sv
// +----------------------------------------------------------------------+
// | axi_rd_id_seq_pkg : shared types/helpers for the AR/R ID tracker     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package axi_rd_id_seq_pkg;

  // Counter must represent 0..max_out inclusive.
  function automatic int cnt_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

  localparam int DEF_SEQ_WIDTH = 4;
  localparam int DEF_CNT_WIDTH = cnt_width(8);

  typedef struct packed {
    logic [DEF_SEQ_WIDTH-1:0] seq;
    logic [DEF_SEQ_WIDTH-1:0] ret;
    logic [DEF_CNT_WIDTH-1:0] cnt;
  } slot_state_t;

endpackage

`default_nettype wire

// File: rtl/axi_rd_id_seq_slot.sv
// +----------------------------------------------------------------------+
// | axi_rd_id_seq_slot : issue tag, retire tag and outstanding count     |
// | for one upstream ID.  rev 1.0                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module axi_rd_id_seq_slot
  import axi_rd_id_seq_pkg::*;
#(
  parameter int SEQ_WIDTH       = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ar_inc_i,
  input  logic                 r_last_i,
  output logic [SEQ_WIDTH-1:0] seq_o,
  output logic [SEQ_WIDTH-1:0] ret_o,
  output logic                 full_o,
  output logic                 zero_o
);

  localparam int CNT_W = cnt_width(MAX_OUTSTANDING);

  logic [SEQ_WIDTH-1:0] seq_q, seq_d;
  logic [SEQ_WIDTH-1:0] ret_q, ret_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 retire;

  // A last beat with nothing outstanding leaves the slot untouched.
  always_comb begin
    retire = r_last_i & (cnt_q != '0);
    seq_d  = seq_q + SEQ_WIDTH'(ar_inc_i);
    ret_d  = ret_q + SEQ_WIDTH'(retire);
    cnt_d  = cnt_q + CNT_W'(ar_inc_i) - CNT_W'(retire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q <= '0;
      ret_q <= '0;
      cnt_q <= '0;
    end else begin
      seq_q <= seq_d;
      ret_q <= ret_d;
      cnt_q <= cnt_d;
    end
  end

  assign seq_o  = seq_q;
  assign ret_o  = ret_q;
  assign full_o = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/axi_rd_id_seq_tracker.sv
// +----------------------------------------------------------------------+
// | axi_rd_id_seq_tracker : per-ID sequence tagging of AR, in-order      |
// | R checking and outstanding-read limiting.  rev 1.0                   |
// +----------------------------------------------------------------------+
`default_nettype none

module axi_rd_id_seq_tracker
  import axi_rd_id_seq_pkg::*;
#(
  parameter int ID_WIDTH        = 2,
  parameter int SEQ_WIDTH       = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                          Aclk,
  input  logic                          ARESETRst,
  input  logic [ID_WIDTH-1:0]           s_ar_id,
  input  logic                          s_ar_valid,
  output logic                          s_ar_ready,
  output logic [SEQ_WIDTH+ID_WIDTH-1:0] m_ar_id,
  output logic                          m_ar_valid,
  input  logic                          m_ar_ready,
  input  logic [SEQ_WIDTH+ID_WIDTH-1:0] m_r_id,
  input  logic                          m_r_valid,
  input  logic                          m_r_last,
  input  logic                          m_r_ready,
  output logic [ID_WIDTH-1:0]           s_r_id,
  output logic                          err_seq,
  output logic                          err_unexp,
  output logic                          idle
);

  localparam int N_IDS = 1 << ID_WIDTH;

  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > (1 << SEQ_WIDTH)) begin : g_param_chk
    $error("MAX_OUTSTANDING out of range 1..2**SEQ_WIDTH");
  end

  logic [SEQ_WIDTH-1:0] seq_arr [N_IDS];
  logic [SEQ_WIDTH-1:0] ret_arr [N_IDS];
  logic [N_IDS-1:0]     full_vec;
  logic [N_IDS-1:0]     zero_vec;

  logic                 ar_full, ar_hs, r_hs, r_last_hs;
  logic [ID_WIDTH-1:0]  r_idx;
  logic [SEQ_WIDTH-1:0] r_tag;
  logic                 err_seq_q, err_seq_d, err_unexp_q, err_unexp_d;

  // Gating uses only registered full flags, so valid never waits on ready.
  assign ar_full    = full_vec[s_ar_id];
  assign m_ar_valid = s_ar_valid & ~ar_full;
  assign s_ar_ready = m_ar_ready & ~ar_full;
  assign ar_hs      = s_ar_valid & m_ar_ready & ~ar_full;
  assign m_ar_id    = {seq_arr[s_ar_id], s_ar_id};

  assign r_idx      = m_r_id[ID_WIDTH-1:0];
  assign r_tag      = m_r_id[SEQ_WIDTH+ID_WIDTH-1:ID_WIDTH];
  assign s_r_id     = r_idx;
  assign r_hs       = m_r_valid & m_r_ready;
  assign r_last_hs  = r_hs & m_r_last;

  for (genvar g = 0; g < N_IDS; g++) begin : g_slot
    axi_rd_id_seq_slot #(
      .SEQ_WIDTH       (SEQ_WIDTH),
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_slot (
      .clk      (Aclk),
      .rst      (ARESETRst),
      .ar_inc_i (ar_hs & (s_ar_id == ID_WIDTH'(g))),
      .r_last_i (r_last_hs & (r_idx == ID_WIDTH'(g))),
      .seq_o    (seq_arr[g]),
      .ret_o    (ret_arr[g]),
      .full_o   (full_vec[g]),
      .zero_o   (zero_vec[g])
    );
  end

  always_comb begin
    err_seq_d   = r_hs & (r_tag != ret_arr[r_idx]);
    err_unexp_d = r_last_hs & zero_vec[r_idx];
  end

  always_ff @(posedge Aclk) begin
    if (ARESETRst) begin
      err_seq_q   <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      err_seq_q   <= err_seq_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  assign err_seq   = err_seq_q;
  assign err_unexp = err_unexp_q;
  assign idle      = &zero_vec;

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_id_seq_tracker.sv
// +----------------------------------------------------------------------+
// | tb_axi_rd_id_seq_tracker : directed bench with a per-ID queue-free   |
// | reference model checked every cycle.  rev 1.0                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_axi_rd_id_seq_tracker;
  import axi_rd_id_seq_pkg::*;

  localparam int IDW  = 2;
  localparam int SEQW = 4;
  localparam int MAXO = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [IDW-1:0]  s_ar_id = '0;
  logic            s_ar_valid = 1'b0;
  logic            s_ar_ready;
  logic [SEQW+IDW-1:0] m_ar_id;
  logic            m_ar_valid;
  logic            m_ar_ready = 1'b0;
  logic [SEQW+IDW-1:0] m_r_id = '0;
  logic            m_r_valid = 1'b0;
  logic            m_r_last = 1'b0;
  logic            m_r_ready = 1'b1;
  logic [IDW-1:0]  s_r_id;
  logic            err_seq, err_unexp, idle;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  axi_rd_id_seq_tracker #(
    .ID_WIDTH(IDW), .SEQ_WIDTH(SEQW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .Aclk(clk), .ARESETRst(rst),
    .s_ar_id(s_ar_id), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .m_ar_id(m_ar_id), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_id(m_r_id), .m_r_valid(m_r_valid), .m_r_last(m_r_last), .m_r_ready(m_r_ready),
    .s_r_id(s_r_id), .err_seq(err_seq), .err_unexp(err_unexp), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-ID issue tag, retire tag and outstanding count.
  slot_state_t mdl [4] = '{default: '0};
  logic exp_err_seq = 1'b0;
  logic exp_err_unexp = 1'b0;

  always @(posedge clk) begin : model
    slot_state_t nx [4];
    logic        full, arhs, rhs;
    logic [1:0]  rid;
    logic [3:0]  rtag;
    nx = mdl;
    if (rst) begin
      for (int i = 0; i < 4; i++) nx[i] = '0;
      exp_err_seq   <= 1'b0;
      exp_err_unexp <= 1'b0;
    end else begin
      full = (int'(mdl[s_ar_id].cnt) == MAXO);
      arhs = s_ar_valid && m_ar_ready && !full;
      rhs  = m_r_valid && m_r_ready;
      rid  = m_r_id[1:0];
      rtag = m_r_id[5:2];
      exp_err_seq   <= rhs && (rtag != mdl[rid].ret);
      exp_err_unexp <= rhs && m_r_last && (mdl[rid].cnt == 0);
      if (arhs) begin
        nx[s_ar_id].seq = nx[s_ar_id].seq + 1;
        nx[s_ar_id].cnt = nx[s_ar_id].cnt + 1;
      end
      if (rhs && m_r_last && mdl[rid].cnt != 0) begin
        nx[rid].ret = nx[rid].ret + 1;
        nx[rid].cnt = nx[rid].cnt - 1;
      end
    end
    mdl <= nx;
  end

  always @(negedge clk) begin : compare
    logic full, all_zero;
    if (chk_en) begin
      full = (int'(mdl[s_ar_id].cnt) == MAXO);
      all_zero = 1'b1;
      for (int i = 0; i < 4; i++) if (mdl[i].cnt != 0) all_zero = 1'b0;
      chk("m_ar_valid", 32'(m_ar_valid), 32'(s_ar_valid && !full));
      chk("s_ar_ready", 32'(s_ar_ready), 32'(m_ar_ready && !full));
      chk("m_ar_id",    32'(m_ar_id),    32'({mdl[s_ar_id].seq, s_ar_id}));
      chk("s_r_id",     32'(s_r_id),     32'(m_r_id[1:0]));
      chk("err_seq",    32'(err_seq),    32'(exp_err_seq));
      chk("err_unexp",  32'(err_unexp),  32'(exp_err_unexp));
      chk("idle",       32'(idle),       32'(all_zero));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ar(input logic v, input logic [1:0] id);
    s_ar_valid = v;
    s_ar_id    = id;
  endtask

  task automatic set_r(input logic v, input logic [3:0] tag, input logic [1:0] id, input logic last);
    m_r_valid = v;
    m_r_id    = {tag, id};
    m_r_last  = last;
  endtask

  logic [5:0] exp_id1 [3] = '{6'h01, 6'h05, 6'h09};

  initial begin
    step(); step();
    chk_en = 1'b1;
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_err_seq", 32'(err_seq), 32'd0);
    chk("rst_err_unexp", 32'(err_unexp), 32'd0);
    rst = 1'b0;
    m_ar_ready = 1'b1;

    // Three ARs on ID 1: tag 0,1,2 above id 01.
    for (int k = 0; k < 3; k++) begin
      set_ar(1, 1); #2;
      chk("ar_id1_tag", 32'(m_ar_id), 32'(exp_id1[k]));
      step();
    end
    set_ar(0, 1); #2;
    chk("idle_busy", 32'(idle), 32'd0);
    step();

    // Fill ID 2, then one retire frees a slot only after the edge.
    for (int k = 0; k < MAXO; k++) begin set_ar(1, 2); step(); end
    set_ar(1, 2); #2;
    chk("full_ready", 32'(s_ar_ready), 32'd0);
    chk("full_valid", 32'(m_ar_valid), 32'd0);
    set_r(1, 4'd0, 2'd2, 1); #1;
    chk("no_bypass", 32'(s_ar_ready), 32'd0);
    step();
    set_r(0, 4'd0, 2'd0, 0); #2;
    chk("freed_ready", 32'(s_ar_ready), 32'd1);
    chk("ar9_tag8", 32'(m_ar_id), 32'(6'h22));
    step();
    set_ar(0, 2);

    // Downstream not ready: valid passes, no handshake.
    m_ar_ready = 1'b0; set_ar(1, 0); step();
    m_ar_ready = 1'b1; set_ar(0, 0);

    // ID 0 tag wrap with in-order two-beat bursts.
    for (int k = 0; k < 18; k++) begin
      set_ar(1, 0); step();
      set_ar(0, 0);
      set_r(1, 4'(k % 16), 2'd0, 0); step();
      set_r(1, 4'(k % 16), 2'd0, 1); step();
      set_r(0, 4'd0, 2'd0, 0);
    end
    #2;
    chk("wrap_tag", 32'(m_ar_id), 32'(6'h08));

    // Wrong-tag last beat without ready is ignored.
    m_r_ready = 1'b0; set_r(1, 4'd5, 2'd0, 1); step();
    m_r_ready = 1'b1; set_r(0, 4'd0, 2'd0, 0); #1;
    chk("noready_err_seq", 32'(err_seq), 32'd0);
    chk("noready_err_unexp", 32'(err_unexp), 32'd0);

    // ID 3: four-beat burst with the wrong tag.
    set_ar(1, 3); step(); set_ar(0, 0);
    for (int b = 0; b < 4; b++) begin
      set_r(1, 4'd1, 2'd3, b == 3); step(); #1;
      chk("bad_tag_beat", 32'(err_seq), 32'd1);
    end
    set_r(0, 4'd0, 2'd0, 0); step();
    chk("bad_tag_end", 32'(err_seq), 32'd0);
    set_ar(1, 3); step(); set_ar(0, 0);
    set_r(1, 4'd1, 2'd3, 1); step(); set_r(0, 4'd0, 2'd0, 0); #1;
    chk("ret3_once", 32'(err_seq), 32'd0);

    // ID 0: same-cycle AR and retire with two outstanding.
    set_ar(1, 0); step(); step();
    set_r(1, 4'd2, 2'd0, 1); step();
    set_ar(0, 0); set_r(0, 4'd0, 2'd0, 0); #2;
    chk("same_cyc_seq", 32'(m_ar_id), 32'(6'h14));
    set_r(1, 4'd3, 2'd0, 1); step(); set_r(0, 4'd0, 2'd0, 0); #1;
    chk("same_cyc_ret", 32'(err_seq), 32'd0);
    set_r(1, 4'd4, 2'd0, 1); step(); set_r(0, 4'd0, 2'd0, 0);

    // ID 1: drain, then an unexpected last.
    for (int k = 0; k < 3; k++) begin set_r(1, 4'(k), 2'd1, 1); step(); end
    set_r(1, 4'd3, 2'd1, 1); step(); set_r(0, 4'd0, 2'd0, 0); #1;
    chk("unexp_pulse", 32'(err_unexp), 32'd1);
    chk("unexp_seq_ok", 32'(err_seq), 32'd0);
    step();
    chk("unexp_end", 32'(err_unexp), 32'd0);
    set_ar(1, 1); #2;
    chk("unexp_seq_kept", 32'(m_ar_id), 32'(6'h0D));
    step(); set_ar(0, 0);
    set_r(1, 4'd3, 2'd1, 1); step(); set_r(0, 4'd0, 2'd0, 0); #1;
    chk("unexp_ret_kept", 32'(err_seq | err_unexp), 32'd0);

    // Reset mid-burst, then the stale last beat arrives.
    set_ar(1, 1); step(); set_ar(0, 2);
    set_r(1, 4'd4, 2'd1, 0); step();
    rst = 1'b1; step();
    rst = 1'b0; set_r(0, 4'd0, 2'd0, 0); #1;
    chk("mid_rst_idle", 32'(idle), 32'd1);
    chk("mid_rst_err", 32'(err_seq | err_unexp), 32'd0);
    chk("mid_rst_seq", 32'(m_ar_id), 32'(6'h02));
    set_r(1, 4'd4, 2'd1, 1); step(); set_r(0, 4'd0, 2'd0, 0); #1;
    chk("stale_unexp", 32'(err_unexp), 32'd1);
    chk("stale_seq", 32'(err_seq), 32'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
